// File: rtl/store_chk_pkg.sv
// Shared types for the store-trace checker: FSM states, failure codes, table entry.
package store_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ADDR    = 2'd1,
    FC_DATA    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_entry_t;

endpackage

// File: rtl/store_exp_table.sv
// Expected-store table: DEPTH x {addr,data}, one sync write port, one async read port.
module store_exp_table
  import store_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] widx_i,
  input  exp_entry_t               wentry_i,
  input  logic [$clog2(DEPTH)-1:0] ridx_i,
  output exp_entry_t               rd_entry_c_o
);

  exp_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wentry_i;
    end
  end

  assign rd_entry_c_o = mem_q[ridx_i];

endmodule

// File: rtl/store_seq_checker.sv
// Snoops the CPU store bus and checks stores, in order, against a programmed table.
module store_seq_checker
  import store_chk_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1300
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [31:0]                cfg_addr,
  input  logic [31:0]                cfg_data,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic                       arm,
  input  logic                       memwrite,
  input  logic [31:0]                dataaddr,
  input  logic [31:0]                writedata,
  input  logic [31:0]                pc,
  output logic                       milestone,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [31:0]                fail_addr,
  output logic [31:0]                fail_data,
  output logic [31:0]                fail_pc,
  output logic [$clog2(DEPTH):0]     match_count,
  output logic [$clog2(TIMEOUT):0]   cycle_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned CYC_W = $clog2(TIMEOUT) + 1;

  state_e           state_q, state_d;
  fail_code_e       fc_q, fc_d;
  logic [LEN_W-1:0] len_q, len_d, mc_q, mc_d;
  logic [CYC_W-1:0] cc_q, cc_d;
  logic             milestone_q, milestone_d, done_q, done_d, pass_q, pass_d;
  logic [31:0]      faddr_q, faddr_d, fdata_q, fdata_d, fpc_q, fpc_d;

  exp_entry_t       exp_c;
  exp_entry_t       wentry_c;
  logic             tbl_we_c;
  logic [LEN_W-1:0] len_in_c;
  logic             addr_ok_c, data_ok_c, last_c, tmo_c;

  // Table writes are locked out while a run is in progress.
  assign tbl_we_c = cfg_we && (state_q != RUN);
  assign wentry_c = '{addr: cfg_addr, data: cfg_data};

  store_exp_table #(.DEPTH(DEPTH)) u_table (
    .clk_i        (clk),
    .rst_ni       (reset),
    .we_i         (tbl_we_c),
    .widx_i       (cfg_idx),
    .wentry_i     (wentry_c),
    .ridx_i       (mc_q[IDX_W-1:0]),
    .rd_entry_c_o (exp_c)
  );

  assign len_in_c  = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
  assign addr_ok_c = (dataaddr == exp_c.addr);
  assign data_ok_c = (writedata == exp_c.data);
  assign last_c    = (mc_q == (len_q - LEN_W'(1)));
  assign tmo_c     = (cc_q == CYC_W'(TIMEOUT - 1));

  // Next-state and output logic; a completing store outranks the timeout.
  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    len_d       = len_q;
    mc_d        = mc_q;
    cc_d        = cc_q;
    milestone_d = 1'b0;
    done_d      = done_q;
    pass_d      = pass_q;
    faddr_d     = faddr_q;
    fdata_d     = fdata_q;
    fpc_d       = fpc_q;

    if (state_q == RUN) begin
      if (!tmo_c) cc_d = cc_q + CYC_W'(1);
      if (memwrite && !addr_ok_c) begin
        state_d = FAIL;
        fc_d    = FC_ADDR;
        done_d  = 1'b1;
        faddr_d = dataaddr;
        fdata_d = writedata;
        fpc_d   = pc;
      end else if (memwrite && !data_ok_c) begin
        state_d = FAIL;
        fc_d    = FC_DATA;
        done_d  = 1'b1;
        faddr_d = dataaddr;
        fdata_d = writedata;
        fpc_d   = pc;
      end else if (memwrite && last_c) begin
        state_d = PASS;
        mc_d    = len_q;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end else if (tmo_c) begin
        state_d = FAIL;
        fc_d    = FC_TIMEOUT;
        done_d  = 1'b1;
        faddr_d = '0;
        fdata_d = '0;
        fpc_d   = pc;
      end else if (memwrite) begin
        mc_d        = mc_q + LEN_W'(1);
        milestone_d = 1'b1;
      end
    end else if (arm) begin
      len_d   = len_in_c;
      mc_d    = '0;
      cc_d    = '0;
      fc_d    = FC_NONE;
      faddr_d = '0;
      fdata_d = '0;
      fpc_d   = '0;
      if (len_in_c == '0) begin
        state_d = PASS;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end else begin
        state_d = RUN;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fc_q        <= FC_NONE;
      len_q       <= '0;
      mc_q        <= '0;
      cc_q        <= '0;
      milestone_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      faddr_q     <= '0;
      fdata_q     <= '0;
      fpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      len_q       <= len_d;
      mc_q        <= mc_d;
      cc_q        <= cc_d;
      milestone_q <= milestone_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      faddr_q     <= faddr_d;
      fdata_q     <= fdata_d;
      fpc_q       <= fpc_d;
    end
  end

  assign milestone   = milestone_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fc_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;
  assign fail_pc     = fpc_q;
  assign match_count = mc_q;
  assign cycle_count = cc_q;

endmodule

// File: doc/store_seq_checker.md
# store_seq_checker

Synthesizable store-trace checker downstream of the `cpu` top: it snoops the CPU data-memory write bus (`memwrite`, `dataaddr`, `writedata`, `pc`) and compares each store, in order, against a programmed table of expected (address, data) pairs. It reports per-store milestones, a final pass, or a latched failure with diagnostics. This lets self-checking programs run on FPGA or in any bench without per-program checker code.

## Interface
Parameters:
- `DEPTH`, 8, expected-store table entries
- `TIMEOUT`, 1300, RUN cycles allowed before a timeout failure

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  write table entry (honoured only in IDLE/PASS/FAIL)
- `cfg_idx`  in  $clog2(DEPTH)  entry index
- `cfg_addr`  in  32  expected store address
- `cfg_data`  in  32  expected store data
- `cfg_len`  in  $clog2(DEPTH)+1  number of valid entries, sampled on `arm`
- `arm`  in  1  start a check run
- `memwrite`  in  1  CPU store strobe
- `dataaddr`  in  32  CPU store address
- `writedata`  in  32  CPU store data
- `pc`  in  32  CPU PC, captured on failure
- `milestone`  out  1  one-cycle pulse per matched non-final store
- `done`  out  1  run finished (PASS or FAIL), level
- `pass`  out  1  run passed, level
- `fail_code`  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- `fail_addr`, `fail_data`, `fail_pc`  out  32 each  offending store / PC at failure
- `match_count`  out  $clog2(DEPTH)+1  stores matched so far
- `cycle_count`  out  $clog2(TIMEOUT)+1  RUN cycles elapsed

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: accepts `cfg_we` writes; `arm` -> RUN, latches `cfg_len` into `len`, clears `match_count`, `cycle_count`, all fail fields.
- `arm` with `cfg_len`==0 -> PASS directly; `cfg_len` > DEPTH clamped to DEPTH.
- RUN, each cycle with `memwrite`=1: compare against entry[`match_count`].
  - Address differs -> FAIL, code 1 (address checked before data).
  - Address equal, data differs -> FAIL, code 2.
  - Both equal, not last -> `match_count`+1, `milestone` pulse.
  - Both equal, last (`match_count`==`len`-1) -> PASS, `match_count`=`len`; no `milestone`.
- RUN, `cycle_count` increments every cycle; reaching TIMEOUT-1 without a completing store -> FAIL, code 3, `fail_addr`/`fail_data` 0.
- Same-cycle final match and timeout: match wins (PASS).
- On FAIL, capture `dataaddr`, `writedata`, `pc` of the sampled cycle.
- PASS/FAIL are sticky: further stores ignored; `cfg_we` allowed; `arm` restarts as from IDLE.
- `arm` or `cfg_we` in RUN ignored.
- Reset mid-run: immediate return to IDLE, table cleared to zero, all outputs 0.

## Timing
- All inputs sampled on rising `clk`; CPU bus assumed stable at edge.
- Latency 1: `milestone`, `pass`, `done`, `fail_code` change on the edge after the sampled store.
- `milestone` high exactly one cycle per match; back-to-back stores give back-to-back pulses.
- Reset values: every output 0, state IDLE, `len` 0.
- `cfg_we` write visible to a run armed the next cycle; same-cycle `cfg_we`+`arm` in IDLE: write lands, arm honoured, new entry used.

## Structure
- Package `store_chk_pkg`: state enum (IDLE, RUN, PASS, FAIL), fail-code enum (NONE, ADDR, DATA, TIMEOUT).
- Sub-module `store_exp_table`: DEPTH x 64-bit register array, one sync write port, one async read port indexed by `match_count`, async active-low clear.
- Top: FSM, counters, compare, diagnostic capture.

## Test plan
- Table {80:7, 84:7, 88:30}, len 3, stores in order -> two `milestone` pulses, then `pass`=1, `done`=1, `match_count`=3.
- Same table, second store to 92 data 7 -> FAIL, `fail_code`=1, `fail_addr`=92, `fail_pc`=store PC, `match_count`=1.
- Same table, store 88 data 29 as third -> FAIL, `fail_code`=2, `fail_data`=29.
- TIMEOUT=20, no stores -> `fail_code`=3 after 20 RUN cycles, `cycle_count`=19.
- Final store lands on timeout cycle -> PASS; stores after PASS ignored; `arm` restarts with counters cleared.
- Reset asserted mid-run after one match -> all outputs 0 asynchronously, table reads 0, state IDLE.
